// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Shared types and decode helpers for the instruction-decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    // Upper bounds for the record; the stage uses the low bits of each field.
    localparam int MAX_OPW  = 8;
    localparam int MAX_REGW = 8;
    localparam int MAX_MAW  = 16;
    localparam int MAX_IW   = MAX_OPW + 3 * MAX_REGW;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_STORE = 2'd2
    } op_class_t;

    typedef struct packed {
        logic [MAX_OPW-1:0]  opcode;
        logic [MAX_REGW-1:0] ra;
        logic [MAX_REGW-1:0] rb;
        logic [MAX_REGW-1:0] rd;
        logic                ra_en;
        logic                rb_en;
        logic                rd_en;
        logic [MAX_MAW-1:0]  dmaddr;
        logic                mem_en;
        logic                mem_we;
    } decoded_t;

    function automatic logic [MAX_OPW-1:0] op_store_code(input int opw);
        return ~({MAX_OPW{1'b1}} << opw);
    endfunction

    function automatic logic [MAX_OPW-1:0] op_load_code(input int opw);
        return op_store_code(opw) - 1'b1;
    endfunction

    function automatic logic [MAX_IW-1:0] get_field(input logic [MAX_IW-1:0] inst,
                                                    input int lsb, input int width);
        return (inst >> lsb) & ~({MAX_IW{1'b1}} << width);
    endfunction

    function automatic decoded_t decode_inst(input logic [MAX_IW-1:0] inst,
                                             input int opw, input int regw,
                                             input int maw);
        decoded_t           d;
        op_class_t          cls;
        logic [MAX_OPW-1:0] op;
        int                 iw;
        iw  = opw + 3 * regw;
        op  = MAX_OPW'(get_field(inst, iw - opw, opw));
        cls = (op == op_store_code(opw)) ? CLS_STORE :
              (op == op_load_code(opw))  ? CLS_LOAD  : CLS_ALU;
        d        = '0;
        d.opcode = op;
        case (cls)
            CLS_STORE: begin
                d.dmaddr = MAX_MAW'(get_field(inst, 0, maw));
                d.ra     = MAX_REGW'(get_field(inst, maw, regw));
                d.ra_en  = 1'b1;
                d.mem_en = 1'b1;
                d.mem_we = 1'b1;
            end
            CLS_LOAD: begin
                d.dmaddr = MAX_MAW'(get_field(inst, iw - opw - 1 - maw, maw));
                d.rd     = MAX_REGW'(get_field(inst, 0, regw));
                d.rd_en  = 1'b1;
                d.mem_en = 1'b1;
            end
            default: begin
                d.ra    = MAX_REGW'(get_field(inst, 2 * regw, regw));
                d.rb    = MAX_REGW'(get_field(inst, regw, regw));
                d.rd    = MAX_REGW'(get_field(inst, 0, regw));
                d.ra_en = 1'b1;
                d.rb_en = 1'b1;
                d.rd_en = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_skid_buf.sv
// ============================================================================
// Module      : decode_skid_buf
// Description : Two-entry valid/ready skid buffer of decoded records, with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_skid_buf
    import decode_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_flush,
    input  logic     i_valid,
    output logic     o_ready,
    input  decoded_t i_data,
    output logic     o_valid,
    output decoded_t o_data,
    input  logic     i_pop
);

    logic [1:0] r_cnt;
    logic       r_ready;
    decoded_t   r_head;
    decoded_t   r_tail;

    logic       w_push;
    logic       w_pop;
    logic [1:0] w_cnt_nxt;

    always_comb begin
        w_push    = i_valid & r_ready & ~i_flush;
        w_pop     = i_pop & (r_cnt != 2'd0) & ~i_flush;
        w_cnt_nxt = i_flush ? 2'd0 : (r_cnt + 2'(w_push) - 2'(w_pop));
    end

    // Ready is registered from next occupancy so it never depends on i_pop combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_ready <= 1'b1;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt != 2'd2);
            if (w_push && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)))
                r_head <= i_data;
            else if (w_pop && (r_cnt == 2'd2))
                r_head <= r_tail;
            if (w_push && (r_cnt == 2'd1) && !w_pop)
                r_tail <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_head;

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Registered decode stage with skid buffer and RAW/WAW scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter  int OPW  = 4,
    parameter  int REGW = 3,
    parameter  int MAW  = 4,
    localparam int IW   = OPW + 3 * REGW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IW-1:0]        in_inst,
    input  logic                 flush,
    input  logic                 wb_valid,
    input  logic [REGW-1:0]      wb_reg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPW-1:0]       out_opcode,
    output logic [REGW-1:0]      out_ra,
    output logic [REGW-1:0]      out_rb,
    output logic [REGW-1:0]      out_rd,
    output logic                 out_ra_en,
    output logic                 out_rb_en,
    output logic                 out_rd_en,
    output logic [MAW-1:0]       out_dmaddr,
    output logic                 out_mem_en,
    output logic                 out_mem_we,
    output logic [2**REGW-1:0]   busy_regs
);

    logic [2**REGW-1:0] r_busy;
    logic [2**REGW-1:0] w_busy_nxt;
    decoded_t           w_dec;
    decoded_t           w_head;
    logic               w_head_valid;
    logic               w_hazard;
    logic               w_fire;
    logic               w_unused_head;

    assign w_dec = decode_inst(MAX_IW'(in_inst), OPW, REGW, MAW);

    decode_skid_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_dec),
        .o_valid (w_head_valid),
        .o_data  (w_head),
        .i_pop   (w_fire)
    );

    // Disabled fields are zero in the record, so the enables alone gate the lookups.
    assign w_hazard  = (w_head.ra_en & r_busy[w_head.ra[REGW-1:0]])
                     | (w_head.rb_en & r_busy[w_head.rb[REGW-1:0]])
                     | (w_head.rd_en & r_busy[w_head.rd[REGW-1:0]]);
    assign out_valid = w_head_valid & ~w_hazard;
    assign w_fire    = out_valid & out_ready;

    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid)
            w_busy_nxt[wb_reg] = 1'b0;
        if (w_fire && w_head.rd_en)
            w_busy_nxt[w_head.rd[REGW-1:0]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign busy_regs     = r_busy;
    assign out_opcode    = w_head.opcode[OPW-1:0];
    assign out_ra        = w_head.ra[REGW-1:0];
    assign out_rb        = w_head.rb[REGW-1:0];
    assign out_rd        = w_head.rd[REGW-1:0];
    assign out_ra_en     = w_head.ra_en;
    assign out_rb_en     = w_head.rb_en;
    assign out_rd_en     = w_head.rd_en;
    assign out_dmaddr    = w_head.dmaddr[MAW-1:0];
    assign out_mem_en    = w_head.mem_en;
    assign out_mem_we    = w_head.mem_we;
    assign w_unused_head = ^w_head;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, wb_valid, out_valid, out_ready;
    logic [12:0] in_inst;
    logic [2:0]  wb_reg, out_ra, out_rb, out_rd;
    logic [3:0]  out_opcode, out_dmaddr;
    logic        out_ra_en, out_rb_en, out_rd_en, out_mem_en, out_mem_we;
    logic [7:0]  busy_regs;

    always #5 clk = ~clk;

    decode_stage #(.OPW(4), .REGW(3), .MAW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .flush(flush), .wb_valid(wb_valid), .wb_reg(wb_reg), .out_valid(out_valid),
        .out_ready(out_ready), .out_opcode(out_opcode), .out_ra(out_ra), .out_rb(out_rb),
        .out_rd(out_rd), .out_ra_en(out_ra_en), .out_rb_en(out_rb_en), .out_rd_en(out_rd_en),
        .out_dmaddr(out_dmaddr), .out_mem_en(out_mem_en), .out_mem_we(out_mem_we),
        .busy_regs(busy_regs)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] ra, rb, rd;
        logic       ra_en, rb_en, rd_en;
        logic [3:0] dm;
        logic       mem_en, mem_we;
    } exp_t;

    typedef struct {
        logic [12:0] inst;
        exp_t        e;
        logic [7:0]  busy;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       q[$];
    logic [7:0] m_busy = 8'h00;
    logic [2:0] fired[$];

    function automatic exp_t ref_decode(input logic [12:0] x);
        exp_t e;
        e    = '0;
        e.op = x[12:9];
        if (e.op == 4'hF) begin
            e.dm = x[3:0]; e.ra = x[6:4]; e.ra_en = 1; e.mem_en = 1; e.mem_we = 1;
        end else if (e.op == 4'hE) begin
            e.dm = x[7:4]; e.rd = x[2:0]; e.rd_en = 1; e.mem_en = 1;
        end else begin
            e.ra = x[8:6]; e.rb = x[5:3]; e.rd = x[2:0];
            e.ra_en = 1; e.rb_en = 1; e.rd_en = 1;
        end
        return e;
    endfunction

    function automatic bit m_valid();
        if (q.size() == 0) return 0;
        return !((q[0].ra_en && m_busy[q[0].ra]) || (q[0].rb_en && m_busy[q[0].rb]) ||
                 (q[0].rd_en && m_busy[q[0].rd]));
    endfunction

    function automatic exp_t dut_rec();
        return {out_opcode, out_ra, out_rb, out_rd, out_ra_en, out_rb_en, out_rd_en,
                out_dmaddr, out_mem_en, out_mem_we};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("out_valid", out_valid, m_valid());
        chk("in_ready", in_ready, q.size() < 2);
        chk("busy_regs", busy_regs, m_busy);
        if (m_valid()) chk("payload", dut_rec(), q[0]);
    endtask

    // Advance one clock, applying the currently driven inputs to the model too.
    task automatic tick();
        bit   v, inf, outf;
        exp_t hd;
        v    = m_valid();
        inf  = in_valid && (q.size() < 2) && !flush;
        outf = v && out_ready;
        hd   = '0;
        if (out_valid && out_ready) fired.push_back(out_rd);
        if (outf) hd = q[0];
        if (rst) begin
            q.delete();
            m_busy = 8'h00;
        end else begin
            if (flush) q.delete();
            else begin
                if (outf) void'(q.pop_front());
                if (inf) q.push_back(ref_decode(in_inst));
            end
            if (wb_valid) m_busy[wb_reg] = 1'b0;
            if (outf && hd.rd_en) m_busy[hd.rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic writeback(input logic [2:0] r);
        wb_valid = 1; wb_reg = r;
        tick();
        wb_valid = 0;
    endtask

    vec_t        vecs[7];
    logic [12:0] bp_words[3];
    logic [3:0]  rop;
    logic [2:0]  exp_rd;
    int          idx;
    bit          acc;

    initial begin
        vecs[0] = '{13'h0253, '{4'h1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0}, 8'h08};
        vecs[1] = '{13'h1C54, '{4'hE, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0}, 8'h10};
        vecs[2] = '{13'h1E29, '{4'hF, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 1'b1}, 8'h00};
        vecs[3] = '{13'h0FC5, '{4'h7, 3'd7, 3'd0, 3'd5, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0}, 8'h20};
        vecs[4] = '{13'h1DF8, '{4'hE, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0}, 8'h01};
        vecs[5] = '{13'h1FD6, '{4'hF, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 4'h6, 1'b1, 1'b1}, 8'h00};
        vecs[6] = '{13'h1B24, '{4'hD, 3'd4, 3'd4, 3'd4, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0}, 8'h10};
        bp_words[0] = 13'h0401; bp_words[1] = 13'h0402; bp_words[2] = 13'h0403;

        rst = 1; in_valid = 0; in_inst = '0; flush = 0; wb_valid = 0; wb_reg = '0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_model();
        chk("reset_outputs", dut_rec(), '0);

        // Table-driven single-instruction decode and scoreboard effect.
        foreach (vecs[i]) begin
            in_valid = 1; in_inst = vecs[i].inst; out_ready = 1;
            tick();
            in_valid = 0;
            chk("vec_out_valid", out_valid, 1'b1);
            chk("vec_payload", dut_rec(), vecs[i].e);
            tick();
            chk("vec_busy", busy_regs, vecs[i].busy);
            if (vecs[i].e.rd_en) writeback(vecs[i].e.rd);
            chk("vec_busy_clear", busy_regs, 8'h00);
        end

        // RAW interlock: second ALU reads r3 written by the first.
        in_valid = 1; in_inst = 13'h0253; tick();
        in_inst = 13'h02C1; tick();
        in_valid = 0;
        chk("raw_held", out_valid, 1'b0);
        tick();
        chk("raw_still_held", out_valid, 1'b0);
        writeback(3'd3);
        chk("raw_released", out_valid, 1'b1);
        chk("raw_rd", out_rd, 3'd1);
        tick();
        writeback(3'd1);
        chk("raw_busy_clear", busy_regs, 8'h00);

        // Backpressure: three words against a stalled consumer.
        out_ready = 0; idx = 0;
        repeat (3) begin
            in_valid = (idx < 3); in_inst = bp_words[idx % 3];
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready_low", in_ready, 1'b0);
        out_ready = 1; fired.delete();
        repeat (10) begin
            in_valid = (idx < 3); in_inst = bp_words[idx % 3];
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 0;
        chk("bp_count", fired.size(), 3);
        for (int k = 0; k < 3; k++) begin
            exp_rd = 3'(k + 1);
            chk("bp_order", (k < fired.size()) ? fired[k] : 3'bx, exp_rd);
        end
        chk("bp_busy", busy_regs, 8'h0E);

        // Flush with two buffered and a simultaneous offer.
        out_ready = 0;
        in_valid = 1; in_inst = 13'h0404; tick();
        in_inst = 13'h0405; tick();
        chk("fl_full", in_ready, 1'b0);
        flush = 1; in_inst = 13'h0406; tick();
        flush = 0; in_valid = 0;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        chk("fl_busy_kept", busy_regs, 8'h0E);
        tick();
        chk("fl_empty", out_valid, 1'b0);
        writeback(3'd1); writeback(3'd2); writeback(3'd3);

        // Reset mid-operation.
        out_ready = 1; in_valid = 1; in_inst = 13'h0253; tick();
        out_ready = 0; in_inst = 13'h0401; tick();
        in_valid = 0; rst = 1; tick();
        rst = 0;
        chk("rst_busy", busy_regs, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(3))
                0:       rop = 4'hE;
                1:       rop = 4'hF;
                default: rop = 4'($urandom_range(13));
            endcase
            in_inst   = {rop, 9'($urandom)};
            in_valid  = $urandom_range(1);
            out_ready = ($urandom_range(3) != 0);
            wb_valid  = ($urandom_range(2) == 0);
            wb_reg    = 3'($urandom);
            flush     = ($urandom_range(39) == 0);
            rst       = ($urandom_range(499) == 0);
            tick();
        end
        rst = 0; flush = 0; in_valid = 0; wb_valid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
